// File: rtl/tft_pkg.sv
// Shared constants, word formatting helpers and FSM encoding for the TFT pixel streamer.
package tft_pkg;

  localparam int TFT_WORD_W = 17;
  localparam int RS_BIT     = 16;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CASET,
    S_CA_X0,
    S_CA_X1,
    S_RASET,
    S_RA_Y0,
    S_RA_Y1,
    S_RAMWR,
    S_PIXELS
  } tft_state_e;

  function automatic logic [TFT_WORD_W-1:0] cmd_word(input logic [7:0] cmd);
    return {1'b0, 8'h00, cmd};
  endfunction

  function automatic logic [TFT_WORD_W-1:0] param_word(input logic [15:0] value);
    return {1'b1, value};
  endfunction

  // Colour-bar palette, left to right.
  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    logic [15:0] c;
    case (bar)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tft_pixel_streamer_if.sv
// Pixel-in and word-out valid/ready streams of the TFT pixel streamer.
interface tft_pixel_streamer_if;
  import tft_pkg::*;

  logic [15:0]           pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [TFT_WORD_W-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  // master = the streamer; slave = pixel producer plus SPI stage
  modport master (
    input  pix_data, pix_valid, word_ready,
    output pix_ready, word_data, word_valid
  );

  modport slave (
    output pix_data, pix_valid, word_ready,
    input  pix_ready, word_data, word_valid
  );

endinterface

// File: rtl/tft_pixel_fifo.sv
// Synchronous FIFO with registered (first-word-not-fall-through) read; depth = 2**AW.
module tft_pixel_fifo #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [DW-1:0] rd_data_q;
  logic          push;
  logic          pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign level   = level_q;
  assign rd_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/tft_pixel_streamer.sv
// Emits CASET/RASET/RAMWR then WIDTH*HEIGHT RGB565 pixels as 17-bit {RS,data} words.
// Optional TFT_PIXEL_PATTERN_EN adds an internal colour-bar source selected by pattern_en.
module tft_pixel_streamer
  import tft_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 160,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0,
  parameter int FIFO_AW  = 4
) (
  input  logic                 MasterCLK,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 pattern_en,
  tft_pixel_streamer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [15:0] X_START = 16'(X_OFFSET);
  localparam logic [15:0] X_END   = 16'(X_OFFSET + WIDTH - 1);
  localparam logic [15:0] Y_START = 16'(Y_OFFSET);
  localparam logic [15:0] Y_END   = 16'(Y_OFFSET + HEIGHT - 1);

  tft_state_e            state_q;
  logic                  start_q;
  logic                  frame_done_q;
  logic                  word_valid_q;
  logic                  pix_valid_q;
  logic [TFT_WORD_W-1:0] word_q;
  logic [CNT_W-1:0]      pix_cnt_q;

  logic                  pix_phase;
  logic                  last_pix;
  logic                  xfer;
  logic                  start_accept;
  logic                  use_fifo;
  logic                  src_valid;
  logic [15:0]           src_data;
  logic [15:0]           fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  out_valid;
  logic [TFT_WORD_W-1:0] out_data;

  assign pix_phase    = (state_q == S_PIXELS);
  assign last_pix     = (pix_cnt_q == LAST_PIX);
  assign xfer         = out_valid && bus.word_ready;
  // A request landing on the frame_done cycle is dropped along with any while busy.
  assign start_accept = frame_start && (state_q == S_IDLE) && !start_q && !frame_done_q;

  // The first pixel is fetched on the RAMWR transfer so the stream has no bubble.
  assign fifo_pop = use_fifo && !fifo_empty &&
                    (((state_q == S_RAMWR) && xfer) ||
                     (pix_phase && (!pix_valid_q || (xfer && !last_pix))));

`ifdef TFT_PIXEL_PATTERN_EN
  localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
  localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_W - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  logic             pat_sel_q;
  logic [COL_W-1:0] col_q;
  logic [SUB_W-1:0] sub_q;
  logic [2:0]       bar_q;

  assign use_fifo  = !pat_sel_q;
  assign src_valid = pat_sel_q ? 1'b1 : pix_valid_q;
  assign src_data  = pat_sel_q ? bar_colour(bar_q) : fifo_rd_data;

  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      pat_sel_q <= 1'b0;
      col_q     <= '0;
      sub_q     <= '0;
      bar_q     <= '0;
    end else if (start_accept) begin
      pat_sel_q <= pattern_en;
      col_q     <= '0;
      sub_q     <= '0;
      bar_q     <= '0;
    end else if (pix_phase && xfer) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        sub_q <= '0;
        bar_q <= '0;
      end else begin
        col_q <= col_q + 1'b1;
        if (sub_q == SUB_LAST) begin
          sub_q <= '0;
          if (bar_q != 3'd7) begin
            bar_q <= bar_q + 1'b1;
          end
        end else begin
          sub_q <= sub_q + 1'b1;
        end
      end
    end
  end
`else
  logic unused_pattern_en;

  assign unused_pattern_en = pattern_en;
  assign use_fifo          = 1'b1;
  assign src_valid         = pix_valid_q;
  assign src_data          = fifo_rd_data;
`endif

  assign out_valid = pix_phase ? src_valid : word_valid_q;
  assign out_data  = pix_phase ? {1'b1, src_data} : word_q;

  assign bus.word_valid = out_valid;
  assign bus.word_data  = out_data;
  assign bus.pix_ready  = !fifo_full;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = frame_done_q;

  tft_pixel_fifo #(
    .DW (16),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (MasterCLK),
    .srst    (reset),
    .wr_en   (bus.pix_valid),
    .wr_data (bus.pix_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      word_valid_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      word_q       <= '0;
      pix_cnt_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      start_q      <= start_accept;

      if (fifo_pop) begin
        pix_valid_q <= 1'b1;
      end else if (pix_phase && xfer) begin
        pix_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_q) begin
            state_q      <= S_CASET;
            word_q       <= cmd_word(CMD_CASET);
            word_valid_q <= 1'b1;
          end
        end
        S_CASET: if (xfer) begin state_q <= S_CA_X0; word_q <= param_word(X_START);   end
        S_CA_X0: if (xfer) begin state_q <= S_CA_X1; word_q <= param_word(X_END);     end
        S_CA_X1: if (xfer) begin state_q <= S_RASET; word_q <= cmd_word(CMD_RASET);   end
        S_RASET: if (xfer) begin state_q <= S_RA_Y0; word_q <= param_word(Y_START);   end
        S_RA_Y0: if (xfer) begin state_q <= S_RA_Y1; word_q <= param_word(Y_END);     end
        S_RA_Y1: if (xfer) begin state_q <= S_RAMWR; word_q <= cmd_word(CMD_RAMWR);   end
        S_RAMWR: begin
          if (xfer) begin
            state_q      <= S_PIXELS;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            pix_cnt_q    <= '0;
          end
        end
        S_PIXELS: begin
          if (xfer) begin
            if (last_pix) begin
              pix_cnt_q    <= '0;
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_pixel_streamer.sv
// Directed bench for tft_pixel_streamer: command sequence, stalls, FIFO fill/drain, abort, pattern.
`timescale 1ns/1ps
module tb_tft_pixel_streamer;
  import tft_pkg::*;

  localparam int NPIX = 128 * 160;

  logic       MasterCLK = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       pattern_en = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [4:0] fifo_level;

  tft_pixel_streamer_if bus ();

  tft_pixel_streamer dut (
    .MasterCLK   (MasterCLK),
    .reset       (reset),
    .frame_start (frame_start),
    .pattern_en  (pattern_en),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .fifo_level  (fifo_level)
  );

  always #5 MasterCLK = ~MasterCLK;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_cmd [7] = '{17'h0002A, 17'h10000, 17'h1007F, 17'h0002B,
                               17'h10000, 17'h1009F, 17'h0002C};
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] f1(input int k);
    return 16'(k) ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] g2(input int k);
    return 16'h1000 + 16'(k);
  endfunction

  initial begin
    int widx, push_idx, px, cyc, np;
    logic early_done, stalled, seen_done;
    logic [16:0] held;

    bus.pix_data   = '0;
    bus.pix_valid  = 1'b0;
    bus.word_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge MasterCLK);
    check("rst_busy",       32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_word_valid", 32'(bus.word_valid), 0);
    check("rst_word_data",  32'(bus.word_data), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_pix_ready",  32'(bus.pix_ready), 1);
    reset = 1'b0;
    @(negedge MasterCLK);

    // Frame 1: latency, command order, full pixel stream, frame_done
    frame_start = 1'b1;
    @(negedge MasterCLK);
    frame_start = 1'b0;
    check("lat_edge_n_valid", 32'(bus.word_valid), 0);
    @(negedge MasterCLK);
    check("lat_edge_n1_valid", 32'(bus.word_valid), 1);
    check("lat_edge_n1_data",  32'(bus.word_data), 32'h0002A);
    check("busy_in_frame",     32'(busy), 1);
    $display("frame1 started");

    bus.word_ready = 1'b1;
    widx = 0; push_idx = 0; cyc = 0; early_done = 1'b0;
    while (widx < NPIX + 7 && cyc < 40000) begin
      bus.pix_valid = (push_idx < NPIX);
      bus.pix_data  = f1(push_idx);
      if (bus.pix_valid && bus.pix_ready) push_idx++;
      if (frame_done) early_done = 1'b1;
      if (bus.word_valid) begin
        if (widx < 7) check("f1_cmd", 32'(bus.word_data), 32'(exp_cmd[widx]));
        else          check("f1_pix", 32'(bus.word_data), 32'({1'b1, f1(widx - 7)}));
        widx++;
      end
      @(negedge MasterCLK);
      cyc++;
    end
    bus.pix_valid = 1'b0;
    check("f1_word_count",  32'(widx), 32'(NPIX + 7));
    check("f1_early_done",  32'(early_done), 0);
    check("f1_frame_done",  32'(frame_done), 1);
    check("f1_busy_after",  32'(busy), 0);
    check("f1_valid_after", 32'(bus.word_valid), 0);
    @(negedge MasterCLK);
    check("f1_done_pulse_end", 32'(frame_done), 0);
    $display("frame1 done: %0d words", widx);

    // Prefill 16 pixels in IDLE, then hold pix_valid high at full
    bus.word_ready = 1'b0;
    push_idx = 0; cyc = 0;
    while (push_idx < 16 && cyc < 100) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = g2(push_idx);
      if (bus.pix_ready) push_idx++;
      @(negedge MasterCLK);
      cyc++;
    end
    bus.pix_data = g2(16);
    check("fill_level",     32'(fifo_level), 16);
    check("fill_pix_ready", 32'(bus.pix_ready), 0);
    @(negedge MasterCLK);
    check("fill_hold_level", 32'(fifo_level), 16);
    check("fill_hold_ready", 32'(bus.pix_ready), 0);
    $display("fifo prefilled: level %0d", fifo_level);

    // Frame 2: random word_ready through the command phase
    frame_start = 1'b1;
    @(negedge MasterCLK);
    frame_start = 1'b0;
    widx = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (widx < 7 && cyc < 300) begin
      bus.pix_valid = (push_idx < 41);
      bus.pix_data  = g2(push_idx);
      if (bus.pix_valid && bus.pix_ready) push_idx++;
      if (stalled) begin
        check("stall_valid", 32'(bus.word_valid), 1);
        check("stall_data",  32'(bus.word_data), 32'(held));
      end
      bus.word_ready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (bus.word_valid) begin
        if (bus.word_ready) begin
          check("f2_cmd", 32'(bus.word_data), 32'(exp_cmd[widx]));
          widx++;
        end else begin
          stalled = 1'b1;
          held    = bus.word_data;
        end
      end
      @(negedge MasterCLK);
      cyc++;
    end
    check("f2_cmd_count", 32'(widx), 7);
    $display("frame2 commands done");

    // Pixels in FIFO order, producer stops after 41
    bus.word_ready = 1'b1;
    px = 0; cyc = 0;
    while (px < 41 && cyc < 500) begin
      bus.pix_valid = (push_idx < 41);
      bus.pix_data  = g2(push_idx);
      if (bus.pix_valid && bus.pix_ready) push_idx++;
      if (bus.word_valid) begin
        check("f2_pix", 32'(bus.word_data), 32'({1'b1, g2(px)}));
        px++;
      end
      @(negedge MasterCLK);
      cyc++;
    end
    check("f2_pix_count_a", 32'(px), 41);

    // FIFO empty: stream stalls with no filler words
    bus.pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("empty_no_valid", 32'(bus.word_valid), 0);
      check("empty_busy",     32'(busy), 1);
      @(negedge MasterCLK);
    end
    check("empty_level", 32'(fifo_level), 0);
    $display("frame2 stalled on empty fifo at pixel %0d", px);

    // Resume; pixel count continues from where it stalled
    cyc = 0;
    while (px < 100 && cyc < 1000) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = g2(push_idx);
      if (bus.pix_ready) push_idx++;
      if (bus.word_valid) begin
        check("f2_pix", 32'(bus.word_data), 32'({1'b1, g2(px)}));
        px++;
      end
      @(negedge MasterCLK);
      cyc++;
    end
    check("f2_pix_count_b", 32'(px), 100);

    // Abort at pixel 100
    bus.pix_valid = 1'b0;
    reset = 1'b1;
    @(negedge MasterCLK);
    check("abort_busy",       32'(busy), 0);
    check("abort_fifo_level", 32'(fifo_level), 0);
    check("abort_valid",      32'(bus.word_valid), 0);
    check("abort_data",       32'(bus.word_data), 0);
    check("abort_frame_done", 32'(frame_done), 0);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge MasterCLK);
      if (frame_done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 0);
    $display("frame2 aborted at pixel %0d", px);

    // Frame 3: restart from CASET; pattern_en sampled at frame_start
    bus.pix_valid = 1'b1;
    bus.pix_data  = 16'hBEEF;
    @(negedge MasterCLK);
    bus.pix_valid = 1'b0;
    check("f3_prefill_level", 32'(fifo_level), 1);
    pattern_en  = 1'b1;
    frame_start = 1'b1;
    @(negedge MasterCLK);
    frame_start = 1'b0;
    pattern_en  = 1'b0;
`ifdef TFT_PIXEL_PATTERN_EN
    np = 129;
`else
    np = 1;
`endif
    widx = 0; cyc = 0;
    while (widx < 7 + np && cyc < 2000) begin
      if (bus.word_valid) begin
        if (widx < 7) begin
          check("f3_cmd", 32'(bus.word_data), 32'(exp_cmd[widx]));
        end else begin
`ifdef TFT_PIXEL_PATTERN_EN
          check("f3_pattern_pix", 32'(bus.word_data), 32'({1'b1, bars[((widx - 7) % 128) / 16]}));
`else
          check("f3_fifo_pix", 32'(bus.word_data), 32'h1BEEF);
`endif
        end
        widx++;
      end
      @(negedge MasterCLK);
      cyc++;
    end
    check("f3_word_count", 32'(widx), 32'(7 + np));
`ifdef TFT_PIXEL_PATTERN_EN
    check("f3_fifo_untouched", 32'(fifo_level), 1);
`else
    check("f3_fifo_drained", 32'(fifo_level), 0);
`endif
    $display("frame3 checked %0d words", widx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
